alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Registered operand-select stage between instruction decode and the ALU. Selects operand A and operand B from the register file, the EX/MEM and MEM/WB forwarding paths, or the immediate in one of four extension modes, then latches both into a single valid/ready pipeline register. Supports flush for branch/jump squash and keeps a saturating back-pressure counter for performance debug. Replaces the unregistered two-way ALU source selection in the datapath.

## Interface
- WIDTH, 32, datapath width of operands and results
- IMM_WIDTH, 16, width of raw immediate field; WIDTH >= IMM_WIDTH required
- clock  input  1  single clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  decode stage presents a new operation
- in_ready  output  1  stage can accept this cycle
- flush  input  1  squash held and incoming operation
- ALUSrc  input  2  operand B source: 0 register, 1 sign-ext imm, 2 zero-ext imm, 3 upper imm
- fwd_sel_a  input  2  operand A source: 0 register file, 1 EX/MEM, 2 MEM/WB, 3 register file
- fwd_sel_b  input  2  operand B register source, same encoding; used only when ALUSrc == 0
- reg_rs  input  WIDTH  register-file read data for A
- reg_rt  input  WIDTH  register-file read data for B
- exmem_result  input  WIDTH  EX/MEM forwarding value
- memwb_result  input  WIDTH  MEM/WB forwarding value
- immediate  input  IMM_WIDTH  raw immediate field
- out_valid  output  1  operand register holds a valid operation
- out_ready  input  1  ALU stage accepts this cycle
- operand_a  output  WIDTH  registered operand A
- operand_b  output  WIDTH  registered operand B
- clear_stats  input  1  synchronous clear of stall_count
- stall_count  output  16  saturating count of back-pressured cycles

## Operation
- Selection is combinational from current inputs; result is captured on a transfer (in_valid && in_ready && !flush).
- Sign-ext: immediate MSB replicated to WIDTH. Zero-ext: upper bits zero. Upper: immediate in bits [WIDTH-1 : WIDTH-IMM_WIDTH], lower bits zero.
- ALUSrc != 0 ignores fwd_sel_b. fwd_sel value 3 selects the register file (reserved, not an error).
- in_ready = !out_valid || out_ready (throughput one op/cycle, no bubble when full and drained).
- State: EMPTY (out_valid 0) and FULL (out_valid 1).
- EMPTY -> FULL on transfer. FULL -> FULL on transfer while out_ready (replace). FULL -> EMPTY on out_ready without transfer. FULL holds, operands unchanged, while !out_ready.
- flush: next state EMPTY regardless of in_valid/out_ready; incoming op dropped; operand registers keep old values (don't-care while invalid).
- stall_count increments each cycle out_valid && !out_ready && !flush; saturates at 0xFFFF; clear_stats has priority over increment.

## Timing
- Reset (asynchronous assert, any time, including mid-stall): out_valid 0, operand_a 0, operand_b 0, stall_count 0; in_ready therefore 1 immediately.
- Release of reset_n synchronous to clock; first capture on first rising edge with reset_n high.
- Latency: one cycle from transfer edge to out_valid/operands visible.
- Operands stable whenever out_valid && !out_ready holds; changes only on the edge that completes the downstream handshake or flush.
- Forwarding inputs sampled only on the transfer edge; later changes do not affect a held operation.
- flush and in_valid on same edge: flush wins, out_valid 0 next cycle.

## Test plan
- Reset: reset_n low mid-stall with stall_count 5 -> out_valid 0, operands 0, stall_count 0, in_ready 1 without clock edge.
- Immediate modes, immediate 0x8000, ALUSrc 1/2/3 -> operand_b 0xFFFF8000 / 0x00008000 / 0x80000000, each one cycle after transfer.
- Forwarding: reg_rs 0x11, exmem 0x22, memwb 0x33, fwd_sel_a 0..3 -> operand_a 0x11, 0x22, 0x33, 0x11; ALUSrc 1 with fwd_sel_b 1 -> operand_b is immediate, not 0x22.
- Back-pressure: out_ready low 4 cycles with in_valid high -> in_ready 0, operands held, stall_count +4; out_ready high with in_valid -> next op captured same edge, no bubble.
- Saturation: hold stall 70000 cycles -> stall_count 0xFFFF; clear_stats same cycle as stall -> 0.
- Flush: flush with in_valid high while FULL and out_ready low -> out_valid 0 next cycle, dropped op never appears, following op captured normally.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Operand A/B select with forwarding and immediate extension,
// latched into a single valid/ready pipeline register.
module alu_operand_stage #(
   parameter int WIDTH     = 32,
   parameter int IMM_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 flush,
   input  logic [1:0]           ALUSrc,
   input  logic [1:0]           fwd_sel_a,
   input  logic [1:0]           fwd_sel_b,
   input  logic [WIDTH-1:0]     reg_rs,
   input  logic [WIDTH-1:0]     reg_rt,
   input  logic [WIDTH-1:0]     exmem_result,
   input  logic [WIDTH-1:0]     memwb_result,
   input  logic [IMM_WIDTH-1:0] immediate,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     operand_a,
   output logic [WIDTH-1:0]     operand_b,
   input  logic                 clear_stats,
   output logic [15:0]          stall_count
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [15:0]      stall_q, stall_d;

   logic [WIDTH-1:0] sel_a, sel_b, reg_b;
   logic [WIDTH-1:0] imm_sx, imm_zx, imm_up;
   logic             xfer;

   assign out_valid   = (state_q == FULL);
   assign in_ready    = !out_valid || out_ready;
   assign xfer        = in_valid && in_ready && !flush;
   assign operand_a   = op_a_q;
   assign operand_b   = op_b_q;
   assign stall_count = stall_q;

   // Built by overlay so WIDTH == IMM_WIDTH needs no zero-width replication.
   always_comb begin
      imm_sx = {WIDTH{immediate[IMM_WIDTH-1]}};
      imm_sx[IMM_WIDTH-1:0] = immediate;
      imm_zx = '0;
      imm_zx[IMM_WIDTH-1:0] = immediate;
      imm_up = '0;
      imm_up[WIDTH-1 -: IMM_WIDTH] = immediate;
   end

   always_comb begin
      sel_a = reg_rs;
      unique case (fwd_sel_a)
         2'd1:    sel_a = exmem_result;
         2'd2:    sel_a = memwb_result;
         default: sel_a = reg_rs;
      endcase
   end

   always_comb begin
      reg_b = reg_rt;
      unique case (fwd_sel_b)
         2'd1:    reg_b = exmem_result;
         2'd2:    reg_b = memwb_result;
         default: reg_b = reg_rt;
      endcase
   end

   always_comb begin
      sel_b = reg_b;
      unique case (ALUSrc)
         2'd1:    sel_b = imm_sx;
         2'd2:    sel_b = imm_zx;
         2'd3:    sel_b = imm_up;
         default: sel_b = reg_b;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      stall_d = stall_q;
      if (flush) begin
         state_d = EMPTY;
      end else if (xfer) begin
         state_d = FULL;
      end else if (out_ready) begin
         state_d = EMPTY;
      end
      if (xfer) begin
         op_a_d = sel_a;
         op_b_d = sel_b;
      end
      if (clear_stats) begin
         stall_d = '0;
      end else if (out_valid && !out_ready && !flush
                   && stall_q != 16'hFFFF) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         op_a_q  <= '0;
         op_b_q  <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         stall_q <= stall_d;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with an expected-operand
// scoreboard popped when the stage presents each captured op.
module tb_alu_operand_stage;
   localparam int W  = 32;
   localparam int IW = 16;

   logic          clock = 1'b0;
   logic          reset_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          flush = 1'b0;
   logic [1:0]    ALUSrc = '0;
   logic [1:0]    fwd_sel_a = '0;
   logic [1:0]    fwd_sel_b = '0;
   logic [W-1:0]  reg_rs = '0;
   logic [W-1:0]  reg_rt = '0;
   logic [W-1:0]  exmem_result = '0;
   logic [W-1:0]  memwb_result = '0;
   logic [IW-1:0] immediate = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  operand_a;
   logic [W-1:0]  operand_b;
   logic          clear_stats = 1'b0;
   logic [15:0]   stall_count;

   alu_operand_stage #(.WIDTH(W), .IMM_WIDTH(IW)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .ALUSrc(ALUSrc), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
      .reg_rs(reg_rs), .reg_rt(reg_rt),
      .exmem_result(exmem_result), .memwb_result(memwb_result),
      .immediate(immediate), .out_valid(out_valid),
      .out_ready(out_ready), .operand_a(operand_a),
      .operand_b(operand_b), .clear_stats(clear_stats),
      .stall_count(stall_count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic op(input logic v, input logic [1:0] src,
                     input logic [1:0] fa, input logic [1:0] fb,
                     input logic [IW-1:0] imm);
      in_valid  = v;
      ALUSrc    = src;
      fwd_sel_a = fa;
      fwd_sel_b = fb;
      immediate = imm;
   endtask

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
      sb.push_back({a, b});
   endtask

   task automatic pop_chk(input string tag);
      exp_t e;
      chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      n_tests++;
      assert (sb.size() > 0) else begin
         n_fail++;
         $error("FAIL %s: got empty scoreboard expected entry", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_a"}, operand_a, e.a);
         chk({tag, "_b"}, operand_b, e.b);
      end
   endtask

   initial begin
      logic [W-1:0] fwd_exp [4];
      fwd_exp = '{32'h11, 32'h22, 32'h33, 32'h11};

      // asynchronous reset before any clock edge
      #2 reset_n = 1'b0;
      #1;
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_a", operand_a, 32'd0);
      chk("rst_b", operand_b, 32'd0);
      chk("rst_stall", {16'b0, stall_count}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      reg_rs       = 32'h11;
      reg_rt       = 32'h44;
      exmem_result = 32'h22;
      memwb_result = 32'h33;
      out_ready    = 1'b1;

      op(1'b1, 2'd1, 2'd0, 2'd0, 16'h8000);
      push(32'h11, 32'hFFFF8000);
      tick();
      pop_chk("sext");
      op(1'b1, 2'd2, 2'd0, 2'd0, 16'h8000);
      push(32'h11, 32'h00008000);
      tick();
      pop_chk("zext");
      op(1'b1, 2'd3, 2'd0, 2'd0, 16'h8000);
      push(32'h11, 32'h80000000);
      tick();
      pop_chk("upper");

      for (int i = 0; i < 4; i++) begin
         op(1'b1, 2'd0, 2'(i), 2'd0, 16'h0);
         push(fwd_exp[i], 32'h44);
         tick();
         pop_chk($sformatf("fwd_a%0d", i));
      end

      op(1'b1, 2'd1, 2'd0, 2'd1, 16'h0005);
      push(32'h11, 32'h5);
      tick();
      pop_chk("imm_over_fwd");
      op(1'b1, 2'd0, 2'd0, 2'd2, 16'h0005);
      push(32'h11, 32'h33);
      tick();
      pop_chk("fwd_b_memwb");

      in_valid = 1'b0;
      tick();
      chk("drain", {31'b0, out_valid}, 32'd0);
      chk("no_stall", {16'b0, stall_count}, 32'd0);

      // back-pressure: X held while Y waits
      reg_rs = 32'hA0A0;
      reg_rt = 32'hB0B0;
      op(1'b1, 2'd0, 2'd0, 2'd0, 16'h0);
      out_ready = 1'b0;
      push(32'hA0A0, 32'hB0B0);
      tick();
      pop_chk("bp_cap");
      reg_rs       = 32'hC0C0;
      reg_rt       = 32'hD0D0;
      exmem_result = 32'hEEEE;
      for (int i = 0; i < 4; i++) begin
         chk("bp_ready", {31'b0, in_ready}, 32'd0);
         tick();
         chk("bp_hold_a", operand_a, 32'hA0A0);
         chk("bp_hold_b", operand_b, 32'hB0B0);
      end
      chk("bp_stall4", {16'b0, stall_count}, 32'd4);
      out_ready = 1'b1;
      #1;
      chk("bp_ready_hi", {31'b0, in_ready}, 32'd1);
      push(32'hC0C0, 32'hD0D0);
      tick();
      pop_chk("bp_next");

      // flush while full and stalled
      out_ready = 1'b0;
      in_valid  = 1'b0;
      tick();
      chk("pre_flush_a", operand_a, 32'hC0C0);
      chk("pre_flush_st", {16'b0, stall_count}, 32'd5);
      reg_rs = 32'hDEAD;
      flush  = 1'b1;
      op(1'b1, 2'd0, 2'd0, 2'd0, 16'h0);
      tick();
      chk("flush_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_stall", {16'b0, stall_count}, 32'd5);
      flush     = 1'b0;
      reg_rs    = 32'h5A5A;
      reg_rt    = 32'h6B6B;
      out_ready = 1'b1;
      push(32'h5A5A, 32'h6B6B);
      tick();
      pop_chk("post_flush");

      // reset in the middle of a stall
      clear_stats = 1'b1;
      reg_rs      = 32'h77;
      reg_rt      = 32'h88;
      push(32'h77, 32'h88);
      tick();
      pop_chk("v_cap");
      chk("clr", {16'b0, stall_count}, 32'd0);
      clear_stats = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      repeat (5) tick();
      chk("stall5", {16'b0, stall_count}, 32'd5);
      #3 reset_n = 1'b0;
      #1;
      chk("mrst_valid", {31'b0, out_valid}, 32'd0);
      chk("mrst_ready", {31'b0, in_ready}, 32'd1);
      chk("mrst_a", operand_a, 32'd0);
      chk("mrst_b", operand_b, 32'd0);
      chk("mrst_stall", {16'b0, stall_count}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // saturation
      reg_rs    = 32'h1;
      reg_rt    = 32'h2;
      out_ready = 1'b1;
      op(1'b1, 2'd0, 2'd0, 2'd0, 16'h0);
      push(32'h1, 32'h2);
      tick();
      pop_chk("sat_cap");
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (65540) tick();
      chk("sat", {16'b0, stall_count}, 32'hFFFF);
      chk("sat_hold", operand_a, 32'h1);
      clear_stats = 1'b1;
      tick();
      chk("sat_clr", {16'b0, stall_count}, 32'd0);
      clear_stats = 1'b0;
      tick();
      chk("after_clr", {16'b0, stall_count}, 32'd1);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
